// File: rtl/bus_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM state encoding
// and default address/data widths.
package bus_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      GRANT0 = 2'b01,
      GRANT1 = 2'b10
   } state_t;

   localparam int ADDR_W_DEFAULT = 16;
   localparam int DATA_W_DEFAULT = 64;

endpackage : bus_pkg

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with a bounded hold time.
//
// Request/grant handshake: a master raises mx_req and keeps it high for as
// long as it wants the bus. The grant appears one clock edge after the
// request is first sampled and stays high while the request stays high,
// unless the other master is waiting and this master has already held the
// bus for MAX_HOLD consecutive cycles. A dropped request reaches bus_req in
// the same cycle. A preempted master simply keeps requesting and is granted
// again later; nothing about it is queued here.
//
// The dbg_* outputs expose the FSM state, hold counter and last_served bit.
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int MAX_HOLD = 4,
   parameter int ADDR_W   = ADDR_W_DEFAULT,
   parameter int DATA_W   = DATA_W_DEFAULT,
   localparam int HOLD_W  = $clog2(MAX_HOLD)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m1_req,
   input  logic              m0_wr,
   input  logic              m1_wr,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m0_dout,
   input  logic [DATA_W-1:0] m1_dout,
   output logic              m0_grant,
   output logic              m1_grant,
   output logic              bus_req,
   output logic              bus_wr,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_dout,
   output state_t            dbg_state,
   output logic [HOLD_W-1:0] dbg_hold_cnt,
   output logic              dbg_last_served
);

   // Hold count value on the last cycle a master may keep the bus while
   // the other one waits.
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_t            state;
   state_t            state_next;
   logic [HOLD_W-1:0] hold_cnt;
   logic [HOLD_W-1:0] hold_next;
   logic              last_served;
   logic              last_next;

   // State, hold counter and round-robin pointer; reset drops any grant at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         hold_cnt    <= '0;
         last_served <= 1'b1;
      end else begin
         state       <= state_next;
         hold_cnt    <= hold_next;
         last_served <= last_next;
      end
   end

   // Next-state: round-robin from IDLE, handover on release, preemption at hold limit.
   always_comb begin
      state_next = state;
      hold_next  = hold_cnt;
      last_next  = last_served;
      case (state)
         IDLE: begin
            hold_next = '0;
            if (m0_req && m1_req) begin
               if (last_served) begin
                  state_next = GRANT0;
                  last_next  = 1'b0;
               end else begin
                  state_next = GRANT1;
                  last_next  = 1'b1;
               end
            end else if (m0_req) begin
               state_next = GRANT0;
               last_next  = 1'b0;
            end else if (m1_req) begin
               state_next = GRANT1;
               last_next  = 1'b1;
            end
         end
         GRANT0: begin
            if (!m0_req) begin
               hold_next = '0;
               if (m1_req) begin
                  state_next = GRANT1;
                  last_next  = 1'b1;
               end else begin
                  state_next = IDLE;
               end
            end else if (hold_cnt == HOLD_LAST) begin
               hold_next = '0;
               if (m1_req) begin
                  state_next = GRANT1;
                  last_next  = 1'b1;
               end
            end else begin
               hold_next = hold_cnt + HOLD_W'(1);
            end
         end
         GRANT1: begin
            if (!m1_req) begin
               hold_next = '0;
               if (m0_req) begin
                  state_next = GRANT0;
                  last_next  = 1'b0;
               end else begin
                  state_next = IDLE;
               end
            end else if (hold_cnt == HOLD_LAST) begin
               hold_next = '0;
               if (m0_req) begin
                  state_next = GRANT0;
                  last_next  = 1'b0;
               end
            end else begin
               hold_next = hold_cnt + HOLD_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            hold_next  = '0;
         end
      endcase
   end

   assign m0_grant = (state == GRANT0);
   assign m1_grant = (state == GRANT1);

   // Bus master port follows the granted master; all zero when nobody holds the bus.
   always_comb begin
      bus_req  = 1'b0;
      bus_wr   = 1'b0;
      bus_addr = '0;
      bus_dout = '0;
      if (m0_grant) begin
         bus_req  = m0_req;
         bus_wr   = m0_wr;
         bus_addr = m0_addr;
         bus_dout = m0_dout;
      end else if (m1_grant) begin
         bus_req  = m1_req;
         bus_wr   = m1_wr;
         bus_addr = m1_addr;
         bus_dout = m1_dout;
      end
   end

   assign dbg_state       = state;
   assign dbg_hold_cnt    = hold_cnt;
   assign dbg_last_served = last_served;

endmodule : bus_arbiter
